ble_cmd_scheduler: RTL and testbench

BLE_CMD_SCHEDULER -- requirements
Module: ble_cmd_scheduler

---
 rtl/ble_cmd_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_ble_cmd_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ble_cmd_scheduler.sv
// BLE command scheduler: parses A5/CMD/ARG/CHK packets from a UART byte stream,
// buffers good commands in a FIFO and releases at most one per video frame.
module ble_cmd_scheduler #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 74250
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid_in,
    input  logic                          new_frame_in,
    input  logic                          cmd_ready_in,
    output logic                          cmd_valid_out,
    output logic [7:0]                    cmd_out,
    output logic [7:0]                    arg_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic [7:0]                    err_count_out,
    output logic                          overflow_out,
    output logic [1:0]                    parser_state_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    HDR_BYTE  = 8'hA5;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        GET_CMD = 2'd1,
        GET_ARG = 2'd2,
        GET_CHK = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]      pkt_cmd_q, pkt_cmd_d;
    logic [7:0]      pkt_arg_q, pkt_arg_d;
    logic            timeout;
    logic            pkt_ok;
    logic            pkt_bad;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            load;
    logic            drop;

    logic            valid_q, valid_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      arg_q, arg_d;
    logic            token_q, token_d;
    logic [7:0]      err_q, err_d;
    logic            ovf_q, ovf_d;

    // Parser FSM: state register
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Parser FSM: next state; only a byte strobe or the timeout moves it
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = HUNT;
        end else if (byte_valid_in) begin
            case (state_q)
                HUNT:    state_d = (byte_in == HDR_BYTE) ? GET_CMD : HUNT;
                GET_CMD: state_d = GET_ARG;
                GET_ARG: state_d = GET_CHK;
                GET_CHK: state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // Parser FSM: outputs (field latches, checksum verdict, timeout)
    always_comb begin
        pkt_cmd_d = pkt_cmd_q;
        pkt_arg_d = pkt_arg_q;
        timeout   = (state_q != HUNT) && !byte_valid_in && (to_cnt_q == TO_LAST);
        pkt_ok    = (state_q == GET_CHK) && byte_valid_in && (byte_in == (pkt_cmd_q ^ pkt_arg_q));
        pkt_bad   = (state_q == GET_CHK) && byte_valid_in && (byte_in != (pkt_cmd_q ^ pkt_arg_q));
        if (byte_valid_in && (state_q == GET_CMD)) begin
            pkt_cmd_d = byte_in;
        end
        if (byte_valid_in && (state_q == GET_ARG)) begin
            pkt_arg_d = byte_in;
        end
        if ((state_q == HUNT) || byte_valid_in || timeout) begin
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            to_cnt_q  <= '0;
            pkt_cmd_q <= '0;
            pkt_arg_q <= '0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            pkt_cmd_q <= pkt_cmd_d;
            pkt_arg_q <= pkt_arg_d;
        end
    end

    // FIFO: a pop frees the head in the same cycle, so a full FIFO still accepts a push then
    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        load       = !valid_q && token_q && !fifo_empty;
        push       = pkt_ok && (!fifo_full || load);
        drop       = pkt_ok && fifo_full && !load;
        wr_ptr_d   = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d   = load ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d    = count_q;
        if (push && !load) begin
            count_d = count_q + CW'(1);
        end else if (!push && load) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {pkt_cmd_q, pkt_arg_q};
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Output register, frame token and status counters
    always_comb begin
        valid_d = valid_q;
        cmd_d   = cmd_q;
        arg_d   = arg_q;
        if (load) begin
            valid_d = 1'b1;
            cmd_d   = mem_q[rd_ptr_q][15:8];
            arg_d   = mem_q[rd_ptr_q][7:0];
        end else if (valid_q && cmd_ready_in) begin
            valid_d = 1'b0;
        end
        // A frame strobe wins over the clear caused by a load in the same cycle
        if (new_frame_in) begin
            token_d = 1'b1;
        end else if (load) begin
            token_d = 1'b0;
        end else begin
            token_d = token_q;
        end
        err_d = err_q;
        if ((pkt_bad || timeout) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
            arg_q   <= '0;
            token_q <= 1'b0;
            err_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            token_q <= token_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cmd_valid_out    = valid_q;
    assign cmd_out          = cmd_q;
    assign arg_out          = arg_q;
    assign fifo_count_out   = count_q;
    assign err_count_out    = err_q;
    assign overflow_out     = ovf_q;
    assign parser_state_out = state_q;

endmodule

// File: tb/tb_ble_cmd_scheduler.sv
// Scenario bench for ble_cmd_scheduler: a scoreboard queue holds the commands
// expected at the output; a monitor pops and compares on every accepted handshake.
module tb_ble_cmd_scheduler;

    localparam int DEPTH = 4;
    localparam int TO    = 200;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid_in = 1'b0;
    logic       new_frame_in = 1'b0;
    logic       cmd_ready_in = 1'b0;
    logic       cmd_valid_out;
    logic [7:0] cmd_out;
    logic [7:0] arg_out;
    logic [2:0] fifo_count_out;
    logic [7:0] err_count_out;
    logic       overflow_out;
    logic [1:0] parser_state_out;

    int          n_checks = 0;
    int          n_pass = 0;
    int          hs_count = 0;
    int          exp_err = 0;
    logic [15:0] exp_q[$];

    ble_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
        .new_frame_in(new_frame_in), .cmd_ready_in(cmd_ready_in), .cmd_valid_out(cmd_valid_out),
        .cmd_out(cmd_out), .arg_out(arg_out), .fifo_count_out(fifo_count_out),
        .err_count_out(err_count_out), .overflow_out(overflow_out), .parser_state_out(parser_state_out)
    );

    // Clock and reset-free clock generation; inputs change on the falling edge
    always #5 clk_in = ~clk_in;

    // Scoreboard: a handshake that the next rising edge will accept
    always @(negedge clk_in) begin
        logic [15:0] exp;
        #1;
        if (rst_in === 1'b1 && cmd_valid_out === 1'b1 && cmd_ready_in === 1'b1) begin
            hs_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got cmd %02h arg %02h, required no command", cmd_out, arg_out);
            end else begin
                exp = exp_q.pop_front();
                if ({cmd_out, arg_out} !== exp)
                    $display("FAIL sb_order: got %04h, required %04h", {cmd_out, arg_out}, exp);
                else
                    n_pass++;
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid_in = 1'b1;
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        byte_in = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k, input bit expect_push);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(k);
        if (expect_push) exp_q.push_back({c, a});
    endtask

    task automatic frame();
        new_frame_in = 1'b1;
        @(negedge clk_in);
        new_frame_in = 1'b0;
    endtask

    task automatic drain(input int n);
        cmd_ready_in = 1'b1;
        repeat (n) begin
            frame();
            tick(3);
        end
        cmd_ready_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        byte_in = 8'hA5;
        byte_valid_in = 1'b1;
        new_frame_in = 1'b0;
        cmd_ready_in = 1'b0;
        tick(2);
        rst_in = 1'b1;
        byte_valid_in = 1'b0;
        byte_in = 8'h00;
        exp_q.delete();
        exp_err = 0;
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        n_checks++; if (cmd_valid_out !== 1'b0) $display("FAIL rst_valid: got %b, required 0", cmd_valid_out); else n_pass++;
        n_checks++; if (cmd_out !== 8'h00) $display("FAIL rst_cmd: got %02h, required 00", cmd_out); else n_pass++;
        n_checks++; if (arg_out !== 8'h00) $display("FAIL rst_arg: got %02h, required 00", arg_out); else n_pass++;
        n_checks++; if (fifo_count_out !== 3'd0) $display("FAIL rst_count: got %0d, required 0", fifo_count_out); else n_pass++;
        n_checks++; if (err_count_out !== 8'd0) $display("FAIL rst_err: got %0d, required 0", err_count_out); else n_pass++;
        n_checks++; if (overflow_out !== 1'b0) $display("FAIL rst_ovf: got %b, required 0", overflow_out); else n_pass++;
        tick(1);
        n_checks++; if (parser_state_out !== 2'd0) $display("FAIL rst_state: got %0d, required 0", parser_state_out); else n_pass++;
    endtask

    task automatic test_latency_basic();
        int h0;
        frame();
        tick(2);
        n_checks++; if (cmd_valid_out !== 1'b0) $display("FAIL lat_empty_valid: got %b, required 0", cmd_valid_out); else n_pass++;
        send_pkt(8'h03, 8'h10, 8'h13, 1'b1);
        n_checks++; if (fifo_count_out !== 3'd1) $display("FAIL lat_count_n1: got %0d, required 1", fifo_count_out); else n_pass++;
        n_checks++; if (cmd_valid_out !== 1'b0) $display("FAIL lat_valid_n1: got %b, required 0", cmd_valid_out); else n_pass++;
        tick(1);
        n_checks++; if (cmd_valid_out !== 1'b1) $display("FAIL lat_valid_n2: got %b, required 1", cmd_valid_out); else n_pass++;
        n_checks++; if (fifo_count_out !== 3'd0) $display("FAIL lat_count_n2: got %0d, required 0", fifo_count_out); else n_pass++;
        tick(3);
        n_checks++; if (cmd_valid_out !== 1'b1 || cmd_out !== 8'h03 || arg_out !== 8'h10)
            $display("FAIL basic_hold: got v=%b %02h/%02h, required v=1 03/10", cmd_valid_out, cmd_out, arg_out);
        else n_pass++;
        h0 = hs_count;
        cmd_ready_in = 1'b1;
        tick(1);
        cmd_ready_in = 1'b0;
        n_checks++; if (cmd_valid_out !== 1'b0) $display("FAIL basic_drop: got %b, required 0", cmd_valid_out); else n_pass++;
        n_checks++; if (hs_count != h0 + 1) $display("FAIL basic_hs: got %0d, required %0d", hs_count, h0 + 1); else n_pass++;
    endtask

    task automatic test_chk_error();
        send_byte(8'h55);
        send_byte(8'h13);
        n_checks++; if (err_count_out !== 8'(exp_err) || parser_state_out !== 2'd0)
            $display("FAIL hunt_noise: got err=%0d st=%0d, required err=%0d st=0", err_count_out, parser_state_out, exp_err);
        else n_pass++;
        send_pkt(8'h03, 8'h10, 8'hFF, 1'b0);
        exp_err++;
        n_checks++; if (err_count_out !== 8'(exp_err)) $display("FAIL chk_err: got %0d, required %0d", err_count_out, exp_err); else n_pass++;
        n_checks++; if (fifo_count_out !== 3'd0) $display("FAIL chk_count: got %0d, required 0", fifo_count_out); else n_pass++;
        send_pkt(8'h01, 8'h02, 8'h03, 1'b1);
        n_checks++; if (fifo_count_out !== 3'd1) $display("FAIL chk_recover: got %0d, required 1", fifo_count_out); else n_pass++;
        drain(1);
    endtask

    task automatic test_timeout();
        send_byte(8'hA5);
        send_byte(8'h03);
        tick(TO - 1);
        n_checks++; if (parser_state_out !== 2'd2 || err_count_out !== 8'(exp_err))
            $display("FAIL to_early: got st=%0d err=%0d, required st=2 err=%0d", parser_state_out, err_count_out, exp_err);
        else n_pass++;
        tick(1);
        exp_err++;
        n_checks++; if (parser_state_out !== 2'd0 || err_count_out !== 8'(exp_err))
            $display("FAIL to_fire: got st=%0d err=%0d, required st=0 err=%0d", parser_state_out, err_count_out, exp_err);
        else n_pass++;
        send_byte(8'hA5);
        tick(TO - 1);
        send_byte(8'h07);
        n_checks++; if (parser_state_out !== 2'd2 || err_count_out !== 8'(exp_err))
            $display("FAIL to_rearm: got st=%0d err=%0d, required st=2 err=%0d", parser_state_out, err_count_out, exp_err);
        else n_pass++;
        tick(TO);
        exp_err++;
        n_checks++; if (parser_state_out !== 2'd0 || err_count_out !== 8'(exp_err))
            $display("FAIL to_fire2: got st=%0d err=%0d, required st=0 err=%0d", parser_state_out, err_count_out, exp_err);
        else n_pass++;
        send_pkt(8'h01, 8'h02, 8'h03, 1'b1);
        n_checks++; if (fifo_count_out !== 3'd1) $display("FAIL to_recover: got %0d, required 1", fifo_count_out); else n_pass++;
        drain(1);
    endtask

    task automatic test_overflow();
        logic [7:0] c, a;
        n_checks++; if (overflow_out !== 1'b0) $display("FAIL ovf_pre: got %b, required 0", overflow_out); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            c = 8'($urandom_range(0, 255));
            a = 8'($urandom_range(0, 255));
            send_pkt(c, a, c ^ a, i < DEPTH);
        end
        n_checks++; if (fifo_count_out !== 3'd4) $display("FAIL ovf_count: got %0d, required 4", fifo_count_out); else n_pass++;
        n_checks++; if (overflow_out !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", overflow_out); else n_pass++;
        n_checks++; if (err_count_out !== 8'(exp_err)) $display("FAIL ovf_err: got %0d, required %0d", err_count_out, exp_err); else n_pass++;
        cmd_ready_in = 1'b1;
        tick(5);
        n_checks++; if (cmd_valid_out !== 1'b0) $display("FAIL ovf_no_token: got %b, required 0", cmd_valid_out); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            frame();
            tick(3);
            n_checks++; if (fifo_count_out !== 3'(DEPTH - 1 - i))
                $display("FAIL ovf_release: got %0d, required %0d", fifo_count_out, DEPTH - 1 - i);
            else n_pass++;
        end
        cmd_ready_in = 1'b0;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] c, a;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            c = 8'($urandom_range(0, 255));
            a = 8'($urandom_range(0, 255));
            send_pkt(c, a, c ^ a, 1'b1);
        end
        c = 8'h5A;
        a = 8'hC3;
        send_byte(8'hA5);
        send_byte(c);
        byte_in = a;
        byte_valid_in = 1'b1;
        new_frame_in = 1'b1;
        @(negedge clk_in);
        new_frame_in = 1'b0;
        byte_in = c ^ a;
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        exp_q.push_back({c, a});
        n_checks++; if (fifo_count_out !== 3'd4) $display("FAIL pp_count: got %0d, required 4", fifo_count_out); else n_pass++;
        n_checks++; if (overflow_out !== 1'b0) $display("FAIL pp_ovf: got %b, required 0", overflow_out); else n_pass++;
        n_checks++; if (cmd_valid_out !== 1'b1) $display("FAIL pp_valid: got %b, required 1", cmd_valid_out); else n_pass++;
        drain(DEPTH);
        n_checks++; if (fifo_count_out !== 3'd0) $display("FAIL pp_drained: got %0d, required 0", fifo_count_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int h0;
        cmd_ready_in = 1'b1;
        send_pkt(8'h11, 8'h22, 8'h33, 1'b1);
        send_pkt(8'h44, 8'h55, 8'h11, 1'b1);
        tick(4);
        h0 = hs_count;
        frame();
        tick(6);
        n_checks++; if (hs_count != h0 + 1 || fifo_count_out !== 3'd1)
            $display("FAIL b2b_one: got hs=%0d cnt=%0d, required hs=%0d cnt=1", hs_count - h0, fifo_count_out, 1);
        else n_pass++;
        frame();
        tick(4);
        n_checks++; if (hs_count != h0 + 2 || fifo_count_out !== 3'd0)
            $display("FAIL b2b_two: got hs=%0d cnt=%0d, required hs=2 cnt=0", hs_count - h0, fifo_count_out);
        else n_pass++;
        send_pkt(8'h66, 8'h77, 8'h11, 1'b1);
        send_pkt(8'h88, 8'h99, 8'h11, 1'b1);
        new_frame_in = 1'b1;
        tick(2);
        new_frame_in = 1'b0;
        tick(6);
        n_checks++; if (hs_count != h0 + 4 || fifo_count_out !== 3'd0)
            $display("FAIL token_set_wins: got hs=%0d cnt=%0d, required hs=4 cnt=0", hs_count - h0, fifo_count_out);
        else n_pass++;
        cmd_ready_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        send_pkt(8'h0A, 8'h0B, 8'h01, 1'b1);
        send_pkt(8'h0C, 8'h0D, 8'h01, 1'b1);
        send_pkt(8'h0E, 8'h0F, 8'h01, 1'b1);
        frame();
        tick(1);
        send_byte(8'hA5);
        n_checks++; if (cmd_valid_out !== 1'b1 || fifo_count_out !== 3'd2)
            $display("FAIL mid_pre: got v=%b cnt=%0d, required v=1 cnt=2", cmd_valid_out, fifo_count_out);
        else n_pass++;
        rst_in = 1'b0;
        byte_in = 8'hA5;
        byte_valid_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        byte_valid_in = 1'b0;
        exp_q.delete();
        exp_err = 0;
        n_checks++; if ({cmd_valid_out, cmd_out, arg_out, fifo_count_out, err_count_out, overflow_out} !== 28'd0)
            $display("FAIL mid_outputs: got v=%b %02h/%02h cnt=%0d err=%0d ovf=%b, required all 0",
                     cmd_valid_out, cmd_out, arg_out, fifo_count_out, err_count_out, overflow_out);
        else n_pass++;
        send_byte(8'h03);
        send_byte(8'h10);
        send_byte(8'h13);
        n_checks++; if (fifo_count_out !== 3'd0 || parser_state_out !== 2'd0)
            $display("FAIL mid_stray: got cnt=%0d st=%0d, required cnt=0 st=0", fifo_count_out, parser_state_out);
        else n_pass++;
        frame();
        tick(2);
        n_checks++; if (cmd_valid_out !== 1'b0) $display("FAIL mid_no_cmd: got %b, required 0", cmd_valid_out); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency_basic();
        test_chk_error();
        test_timeout();
        test_overflow();
        test_push_pop_full();
        test_back_to_back();
        test_reset_mid();
        n_checks++; if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
